c_rr_arbiter_v4_0: RTL and testbench
====================================

C_RR_ARBITER_V4_0 -- requirements
Module: c_rr_arbiter_v4_0

Interface
REQ-001 Parameter C_NUM_REQ, default 8, SHALL be the number of requesters (2..32).
REQ-002 Parameter C_SEL_WIDTH, default 3, SHALL be the width of the binary grant index, ceil(log2(C_NUM_REQ)).
REQ-003 Parameter C_MAX_HOLD, default 0, SHALL be the maximum grant tenure in enabled cycles (0 = unlimited).
REQ-004 Parameter C_HAS_CE, default 0, SHALL select whether CE is used (0 = CE treated as 1).
REQ-005 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 SCLR_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 CE  input  1  SHALL be the clock enable; when low, all state holds.
REQ-008 REQ  input  C_NUM_REQ  SHALL be the level-sensitive request vector, bit i = requester i.
REQ-009 GNT  output  C_NUM_REQ  SHALL be the registered one-hot grant, all-zero when idle.
REQ-010 GNT_SEL  output  C_SEL_WIDTH  SHALL be the registered binary index of the granted requester, for driving a binary decoder select.
REQ-011 GNT_VALID  output  1  SHALL be high exactly when GNT is non-zero.

Function
REQ-012 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-013 IDLE, CE=1, REQ non-zero: the next edge SHALL grant the first set REQ bit searching from PTR upward modulo C_NUM_REQ, and enter BUSY.
REQ-014 Grant latency SHALL be one cycle: a REQ asserted before edge n yields GNT after edge n.
REQ-015 On each grant to index g, PTR SHALL become (g+1) mod C_NUM_REQ (wrap from C_NUM_REQ-1 to 0).
REQ-016 BUSY SHALL hold GNT/GNT_SEL unchanged while REQ[g]=1 and the tenure limit is not reached.
REQ-017 Release SHALL occur at the edge where REQ[g]=0 is sampled, or where HOLD_CNT = C_MAX_HOLD-1 with C_MAX_HOLD>0.
REQ-018 At release, if any REQ bit is set (searching from the updated PTR), the same edge SHALL grant the next winner (back-to-back, no idle cycle); otherwise the block SHALL enter IDLE with GNT all-zero.
REQ-019 A sole requester still asserting at timeout SHALL be re-granted at that same edge, with HOLD_CNT restarted at 0.
REQ-020 HOLD_CNT SHALL reset to 0 on every new grant and increment once per CE=1 cycle in BUSY; its width SHALL be ceil(log2(C_MAX_HOLD+1)), minimum 1.
REQ-021 REQ bits of non-granted requesters changing during BUSY SHALL NOT affect the current grant.
REQ-022 CE=0 SHALL freeze state, PTR, HOLD_CNT and outputs, including during a pending release.
REQ-023 GNT SHALL never have more than one bit set; GNT_SEL SHALL be 0 when GNT_VALID=0.

Reset
REQ-024 SCLR_N=0 sampled at an edge SHALL force IDLE, GNT=0, GNT_SEL=0, GNT_VALID=0, PTR=0, HOLD_CNT=0, regardless of CE.
REQ-025 Reset asserted during BUSY SHALL drop the grant at that edge; the first post-reset grant SHALL search from index 0.

Structure
REQ-026 State encodings and the C_MAX_HOLD=0 "unlimited" constant SHALL live in the shared baseblocks constants include, not in this module.
REQ-027 The rotating first-set search SHALL be one combinational sub-module, c_rr_pick_v4_0 (inputs REQ, PTR; outputs index, found).
REQ-028 Only GNT, GNT_SEL, GNT_VALID, PTR, HOLD_CNT and state SHALL be registered.

Verification
REQ-029 Reset, then REQ=8'b0000_0101 held -> GNT=8'b0000_0001, GNT_SEL=0 after 1 cycle; drop REQ[0] -> next edge GNT=8'b0000_0100, GNT_SEL=2.
REQ-030 All 8 REQ high, each granted requester drops REQ for one cycle after its grant -> grant order 0,1,2,...,7,0 with no idle cycles.
REQ-031 C_MAX_HOLD=4, REQ=8'b1000_0001 held -> GNT alternates 0 and 7 every 4 cycles; with only REQ[3] held -> GNT stays 3 and HOLD_CNT wraps 0..3.
REQ-032 Granted 6, CE=0 for 5 cycles while REQ[6] drops -> GNT unchanged until CE=1, then release at the next edge.
REQ-033 Granted 5 (PTR=6), SCLR_N=0 one cycle with REQ=8'b0100_0001 -> GNT=0 at reset edge, then GNT=8'b0000_0001 (search from 0).
REQ-034 Random REQ for 10000 cycles -> GNT always one-hot or zero, GNT_SEL matches GNT, and no requester held high waits more than (C_NUM_REQ-1) tenures.

Source files
------------

// File: rtl/c_rr_arbiter_v4_0_pkg.sv
// c_rr_arbiter_v4_0_pkg: shared constants, state encoding and sizing helper for the round-robin arbiter
package c_rr_arbiter_v4_0_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // A maximum hold of zero means a grant is never cut short.
    localparam int C_HOLD_UNLIMITED = 0;

    // The hold counter must reach C_MAX_HOLD-1; it keeps at least one bit even when unused.
    function automatic int hold_width(input int max_hold);
        return ($clog2(max_hold + 1) < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/c_rr_arbiter_v4_0_pick.sv
// c_rr_pick_v4_0: combinational rotating first-set search starting at ptr, wrapping modulo C_NUM_REQ
module c_rr_pick_v4_0
    import c_rr_arbiter_v4_0_pkg::*;
#(
    parameter int C_NUM_REQ   = 8,
    parameter int C_SEL_WIDTH = 3
) (
    input  logic [C_NUM_REQ-1:0]   req,
    input  logic [C_SEL_WIDTH-1:0] ptr,
    output logic [C_SEL_WIDTH-1:0] index,
    output logic                   found
);

    localparam int SW1 = C_SEL_WIDTH + 1;

    logic [C_NUM_REQ-1:0]   rot;
    logic [C_SEL_WIDTH-1:0] off;
    logic [SW1-1:0]         sum;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then map the offset back to a real index.
    always_comb begin
        rot   = C_NUM_REQ'({req, req} >> ptr);
        off   = '0;
        found = 1'b0;
        for (int k = C_NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = C_SEL_WIDTH'(k);
                found = 1'b1;
            end
        end
        sum   = {1'b0, ptr} + {1'b0, off};
        index = C_SEL_WIDTH'((sum >= SW1'(C_NUM_REQ)) ? sum - SW1'(C_NUM_REQ) : sum);
    end

endmodule

// File: rtl/c_rr_arbiter_v4_0.sv
// c_rr_arbiter_v4_0: round-robin arbiter with registered one-hot and binary grant and optional tenure limit
module c_rr_arbiter_v4_0
    import c_rr_arbiter_v4_0_pkg::*;
#(
    parameter int C_NUM_REQ   = 8,
    parameter int C_SEL_WIDTH = 3,
    parameter int C_MAX_HOLD  = 0,
    parameter int C_HAS_CE    = 0
) (
    input  logic                   clk,
    input  logic                   sclr_n,
    input  logic                   ce,
    input  logic [C_NUM_REQ-1:0]   req,
    output logic [C_NUM_REQ-1:0]   gnt,
    output logic [C_SEL_WIDTH-1:0] gnt_sel,
    output logic                   gnt_valid
);

    localparam int HW = hold_width(C_MAX_HOLD);

    arb_state_e             state;
    logic [C_SEL_WIDTH-1:0] ptr;
    logic [HW-1:0]          hold_cnt;
    logic [C_SEL_WIDTH-1:0] pick;
    logic [C_SEL_WIDTH-1:0] ptr_nxt;
    logic                   found;
    logic                   en;
    logic                   timeout;
    logic                   rel;

    c_rr_pick_v4_0 #(
        .C_NUM_REQ  (C_NUM_REQ),
        .C_SEL_WIDTH(C_SEL_WIDTH)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .index(pick),
        .found(found)
    );

    assign en      = (C_HAS_CE != 0) ? ce : 1'b1;
    assign timeout = (C_MAX_HOLD != C_HOLD_UNLIMITED) && (hold_cnt == HW'(C_MAX_HOLD - 1));
    // IDLE is treated as a permanent release so a single path handles first grants and hand-overs.
    assign rel     = (state == ST_IDLE) || !req[gnt_sel] || timeout;
    assign ptr_nxt = (pick == C_SEL_WIDTH'(C_NUM_REQ - 1)) ? '0 : pick + 1'b1;

    // Grant FSM: on release re-arbitrate from ptr (holder last, so a lone holder is re-granted), else count tenure.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_sel   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else if (en) begin
            if (rel) begin
                state     <= found ? ST_BUSY : ST_IDLE;
                gnt       <= found ? C_NUM_REQ'(1) << pick : '0;
                gnt_sel   <= found ? pick : '0;
                gnt_valid <= found;
                ptr       <= found ? ptr_nxt : ptr;
                hold_cnt  <= '0;
            end else begin
                hold_cnt  <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c_rr_arbiter_v4_0.sv
// tb_c_rr_arbiter_v4_0: directed and randomized checks of the round-robin arbiter against an integer reference model
module tb_c_rr_arbiter_v4_0;

    localparam int N  = 8;
    localparam int SW = 3;
    localparam int MH = 4;

    logic          clk    = 1'b0;
    logic          sclr_n = 1'b0;
    logic          ce     = 1'b0;
    logic [N-1:0]  req    = '0;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_sel;
    logic          gnt_valid;

    int n_chk = 0;
    int n_fail = 0;
    int m_g = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int wait_ev[N];
    int max_wait = 0;
    logic          prev_valid = 1'b0;
    logic [SW-1:0] prev_sel   = '0;

    always #5 clk = ~clk;

    c_rr_arbiter_v4_0 #(
        .C_NUM_REQ  (N),
        .C_SEL_WIDTH(SW),
        .C_MAX_HOLD (MH),
        .C_HAS_CE   (1)
    ) dut (
        .clk      (clk),
        .sclr_n   (sclr_n),
        .ce       (ce),
        .req      (req),
        .gnt      (gnt),
        .gnt_sel  (gnt_sel),
        .gnt_valid(gnt_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: holder index (-1 = none), search start and tenure, updated from the arbitration rules.
    task automatic model_step(input logic [N-1:0] r, input logic c, input logic rn);
        if (!rn) begin
            m_g   = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else if (c) begin
            if (m_g < 0 || !r[m_g] || (MH > 0 && m_cnt == MH - 1)) begin
                int w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_g   = w;
                m_cnt = 0;
                if (w >= 0) m_ptr = (w + 1) % N;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic c, input logic rn);
        logic ev;
        @(negedge clk);
        req    = r;
        ce     = c;
        sclr_n = rn;
        model_step(r, c, rn);
        @(posedge clk);
        #1;
        chk("gnt", gnt, (m_g < 0) ? 0 : 32'(1) << m_g);
        chk("gnt_sel", gnt_sel, (m_g < 0) ? 0 : m_g);
        chk("gnt_valid", gnt_valid, m_g >= 0);
        chk("onehot0", $onehot0(gnt), 1);
        chk("sel_match", gnt_valid ? gnt[gnt_sel] : (gnt_sel == 0), 1);
        ev = gnt_valid && (!prev_valid || gnt_sel != prev_sel);
        for (int i = 0; i < N; i++) begin
            if (!rn || !r[i] || (gnt_valid && gnt_sel == SW'(i))) begin
                wait_ev[i] = 0;
            end else if (ev) begin
                wait_ev[i]++;
                if (wait_ev[i] > max_wait) max_wait = wait_ev[i];
            end
        end
        prev_valid = gnt_valid;
        prev_sel   = gnt_sel;
    endtask

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) wait_ev[i] = 0;

        cyc('0, 1'b1, 1'b0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_gnt", gnt, 0);
        cyc(8'h05, 1'b1, 1'b1);
        chk("first_grant", gnt, 8'h01);
        cyc(8'h04, 1'b1, 1'b1);
        chk("handover_sel", gnt_sel, 2);

        cyc('0, 1'b1, 1'b0);
        r = 8'hff;
        for (int k = 0; k <= 8; k++) begin
            cyc(r, 1'b1, 1'b1);
            chk("rotate", gnt, 32'(1) << (k % 8));
            r = 8'hff & ~(8'(1) << (k % 8));
        end

        cyc('0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(8'h81, 1'b1, 1'b1);
            chk("tenure_alt", gnt_sel, ((k / 4) % 2 != 0) ? 7 : 0);
            chk("tenure_cnt", dut.hold_cnt, k % 4);
        end
        cyc('0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            cyc(8'h08, 1'b1, 1'b1);
            chk("sole_regrant", gnt, 8'h08);
            chk("sole_cnt", dut.hold_cnt, k % 4);
        end

        cyc('0, 1'b1, 1'b0);
        cyc(8'h40, 1'b1, 1'b1);
        chk("ce_grant", gnt, 8'h40);
        for (int k = 0; k < 5; k++) begin
            cyc('0, 1'b0, 1'b1);
            chk("ce_freeze", gnt, 8'h40);
        end
        cyc('0, 1'b1, 1'b1);
        chk("ce_release", gnt, 0);

        cyc('0, 1'b1, 1'b0);
        cyc(8'h20, 1'b1, 1'b1);
        chk("pre_rst_grant", gnt, 8'h20);
        cyc(8'h41, 1'b0, 1'b0);
        chk("rst_drop", gnt, 0);
        cyc(8'h41, 1'b1, 1'b1);
        chk("rst_ptr0", gnt, 8'h01);

        r = '0;
        for (int k = 0; k < 10000; k++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cyc(r, $urandom_range(9) != 0, $urandom_range(199) != 0);
        end

        chk("starvation_bound", max_wait <= N - 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
